// File: rtl/halve_tokens.sv
// Serial token halver: measures runs of '1' on a, queues half-lengths, and replays
// them on b. Odd runs, over-long runs and queue overruns raise sticky flags.
module halve_tokens #(
  parameter int MAX_RUN = 400,
  parameter int DEPTH   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic b,
  output logic odd_err,
  output logic overflow,
  output logic busy
);

  localparam int RCW = $clog2(MAX_RUN + 2);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  localparam logic [RCW-1:0] RC_MAX   = RCW'(MAX_RUN);
  localparam logic [RCW-1:0] RC_SAT   = RCW'(MAX_RUN + 1);
  localparam logic [RCW-1:0] E_ONE    = RCW'(1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);

  logic [RCW-1:0] rc_q, rc_d;
  logic [RCW-1:0] e_q, e_d;
  logic [RCW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           odd_q, odd_d;
  logic           ovf_q, ovf_d;

  logic [RCW-1:0] half;
  logic run_end, over_long, push_req, push, pop, drop, q_empty, q_full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    half      = rc_q >> 1;
    run_end   = ~a & (rc_q != '0);
    over_long = a & (rc_q == RC_MAX);
    push_req  = run_end & (rc_q <= RC_MAX) & (half != '0);
    q_empty   = (cnt_q == '0);
    q_full    = (cnt_q == CNT_FULL);
    // Popping while e==1 chains replays with no gap on b.
    pop       = ~q_empty & (e_q <= E_ONE);
    // A full queue still accepts a push when a pop frees a slot in the same cycle.
    push      = push_req & (~q_full | pop);
    drop      = push_req & q_full & ~pop;

    if (a) rc_d = (rc_q == RC_SAT) ? rc_q : rc_q + RCW'(1);
    else   rc_d = '0;

    if (pop)              e_d = mem_q[rd_q];
    else if (e_q != '0)   e_d = e_q - RCW'(1);
    else                  e_d = '0;

    wr_d = push ? ptr_inc(wr_q) : wr_q;
    rd_d = pop  ? ptr_inc(rd_q) : rd_q;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    odd_d = odd_q | (run_end & rc_q[0]);
    ovf_d = ovf_q | over_long | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q  <= '0;
      e_q   <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      odd_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rc_q  <= rc_d;
      e_q   <= e_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      odd_q <= odd_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage needs no reset: validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= half;
  end

  assign b        = (e_q != '0) & ~ovf_q;
  assign odd_err  = odd_q;
  assign overflow = ovf_q;
  assign busy     = (rc_q != '0) | ~q_empty | (e_q != '0);

endmodule

// File: tb/tb_halve_tokens.sv
// Directed bench for halve_tokens: outputs sampled on the falling edge of each cycle,
// a driven for the rising edge that closes the same cycle.
module tb_halve_tokens;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic b, odd_err, overflow, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  halve_tokens #(.MAX_RUN(400), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .odd_err(odd_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  // Drive a for the current cycle, advance to the next cycle's sampling point.
  task automatic step(input logic av);
    a = av;
    @(negedge clk);
    cyc++;
  endtask

  // Leaves the bench at cycle 0 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    cyc = 0;
  endtask

  logic [7:0] pat;

  initial begin
    @(negedge clk);

    // Even run: four ones, b high in cycles 6-7, busy falls in cycle 8
    do_reset();
    chk("reset_b", b, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_odd", odd_err, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    repeat (4) step(1'b1);
    for (int c = 4; c <= 9; c++) begin
      chk("even_b", b, (c == 6) || (c == 7));
      if (c == 7) chk("even_busy7", busy, 1'b1);
      if (c == 8) chk("even_busy8", busy, 1'b0);
      step(1'b0);
    end
    chk("even_odd", odd_err, 1'b0);

    // Odd run: three ones, b high in cycle 5, odd_err from cycle 4 and sticky
    do_reset();
    repeat (3) step(1'b1);
    for (int c = 3; c <= 7; c++) begin
      chk("odd_b", b, c == 5);
      if (c == 3) chk("odd_err3", odd_err, 1'b0);
      if (c == 4) chk("odd_err4", odd_err, 1'b1);
      step(1'b0);
    end
    repeat (100) step(1'b0);
    chk("odd_sticky", odd_err, 1'b1);
    chk("odd_b_idle", b, 1'b0);

    // Back-to-back runs 1,1,0,1,1,1,1,0: b in cycle 4 and cycles 9-10
    do_reset();
    pat = 8'b0111_1011;
    for (int c = 0; c <= 13; c++) begin
      chk("b2b_b", b, (c == 4) || (c == 9) || (c == 10));
      step((c < 8) ? pat[c] : 1'b0);
    end
    chk("b2b_odd", odd_err, 1'b0);
    chk("b2b_ovf", overflow, 1'b0);

    // Queue overrun: 400 ones, a zero, then five "110" runs
    do_reset();
    repeat (400) step(1'b1);
    step(1'b0);
    for (int r = 0; r < 5; r++) begin
      step(1'b1);
      step(1'b1);
      if (r == 4) begin
        chk("ovr_ovf415", overflow, 1'b0);
        chk("ovr_b415", b, 1'b1);
      end
      step(1'b0);
    end
    chk("ovr_ovf416", overflow, 1'b1);
    chk("ovr_b416", b, 1'b0);
    chk("ovr_busy416", busy, 1'b1);
    for (int c = 0; c < 300; c++) begin
      if (b !== 1'b0) chk("ovr_b_stuck", b, 1'b0);
      step(1'b0);
    end
    chk("ovr_ovf_sticky", overflow, 1'b1);
    chk("ovr_odd", odd_err, 1'b0);

    // Over-long run: 401 ones, overflow from cycle 401, never replayed
    do_reset();
    repeat (400) step(1'b1);
    chk("long_ovf400", overflow, 1'b0);
    step(1'b1);
    chk("long_ovf401", overflow, 1'b1);
    step(1'b0);
    step(1'b0);
    chk("long_busy403", busy, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (b !== 1'b0) chk("long_b", b, 1'b0);
      step(1'b0);
    end
    chk("long_b_end", b, 1'b0);

    // Reset mid-replay: single '1' (sets odd_err), then 20 ones; rst in replay cycle 3
    do_reset();
    step(1'b1);
    step(1'b0);
    repeat (20) step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("rmr_b24", b, 1'b1);
    chk("rmr_odd24", odd_err, 1'b1);
    step(1'b0);
    step(1'b0);
    chk("rmr_b26", b, 1'b1);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    chk("rmr_b27", b, 1'b0);
    chk("rmr_busy27", busy, 1'b0);
    chk("rmr_odd27", odd_err, 1'b0);
    chk("rmr_ovf27", overflow, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if ((b !== 1'b0) || (busy !== 1'b0)) chk("rmr_quiet", b | busy, 1'b0);
      step(1'b0);
    end
    chk("rmr_b_end", b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
